fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter placed in front of the asymmetric `fifo` (2·DATA_WIDTH-bit write port, DATA_WIDTH-bit read port). It lets NUM_REQ independent producers share the single `wr`/`w_data` port. It grants bounded bursts of up to MAX_BURST words per owner and never writes while the FIFO reports `full`. Its outputs connect directly to `fifo.wr` and `fifo.w_data`, and `fifo.full` is fed back into it.

---
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of the asymmetric fifo.
// Grants bounded bursts to one requester at a time and never writes while the fifo is full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0]    req_data,
    input  logic                               full,
    output logic [NUM_REQ-1:0]                 ack,
    output logic                               wr,
    output logic [2*DATA_WIDTH-1:0]            w_data,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               busy
);

    localparam int WORD_W = 2 * DATA_WIDTH;
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   owner, owner_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;

    // First active requester at or after rr_ptr, wrapping explicitly for non-power-of-two counts.
    always_comb begin
        logic [ID_W:0] idx;
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!pick_valid && req[idx[ID_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        wr  = 1'b0;
        ack = '0;
        if (state == GRANT) begin
            wr         = req[owner] & ~full;
            ack[owner] = req[owner] & ~full;
        end
    end

    assign w_data   = req_data[owner*WORD_W +: WORD_W];
    assign busy     = (state == GRANT);
    assign grant_id = owner;

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_valid && !full) begin
                    state_nxt     = GRANT;
                    owner_nxt     = pick_id;
                    burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (wr) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
                // A dropped request ends the grant even while stalled on full.
                if (!req[owner] || (wr && burst_cnt == LAST_CNT)) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (owner == LAST_ID) ? '0 : owner + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector table, then scoreboarded requester runs
// covering round-robin order, full stalls, early release, pointer wrap and mid-burst reset.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;
    logic [3:0]  ack;
    logic        wr;
    logic [7:0]  w_data;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic        full;
        logic [31:0] data;
        logic        exp_wr;
        logic [3:0]  exp_ack;
        logic        exp_busy;
        logic [1:0]  exp_gid;
        logic [7:0]  exp_wdata;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    vec_t        vecs[18];
    exp_t        exp_q[$];
    int          pushed  = 0;
    int          written = 0;
    logic [7:0]  src[4][16];
    int          head[4];
    int          tail[4];
    logic [3:0]  last_ack;
    logic [63:0] wr_pat, busy_pat, full_pat;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (4),
        .MAX_BURST  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .ack      (ack),
        .wr       (wr),
        .w_data   (w_data),
        .grant_id (grant_id),
        .busy     (busy)
    );

    task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(logic [3:0] r, logic f, logic [31:0] d, logic ew,
                                logic [3:0] ea, logic eb, logic [1:0] eg, logic [7:0] ed);
        vec_t v;
        v.req = r;   v.full = f;      v.data = d;
        v.exp_wr = ew; v.exp_ack = ea; v.exp_busy = eb;
        v.exp_gid = eg; v.exp_wdata = ed;
        return v;
    endfunction

    function automatic logic [63:0] bits(int lo, int hi);
        logic [63:0] m = '0;
        for (int b = lo; b <= hi; b++) m[b] = 1'b1;
        return m;
    endfunction

    task automatic apply_stimulus(vec_t v);
        @(posedge clk);
        #1;
        req      = v.req;
        full     = v.full;
        req_data = v.data;
    endtask

    // Queue a word at requester i; words that must reach the fifo also go to the scoreboard.
    task automatic load(int i, logic [7:0] d, bit expect_write);
        exp_t e;
        src[i][tail[i]] = d;
        tail[i]++;
        if (expect_write) begin
            e.id   = 2'(i);
            e.data = d;
            exp_q.push_back(e);
            pushed++;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            if (head[i] < tail[i]) begin
                req[i]            = 1'b1;
                req_data[i*8 +: 8] = src[i][head[i]];
            end else begin
                req[i]            = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    task automatic sample_writes();
        exp_t e;
        if (wr) begin
            written++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got write of %0h from %0d, want no write", w_data, grant_id);
            end else begin
                e = exp_q.pop_front();
                check_output("sb grant_id", 32'(grant_id), 32'(e.id));
                check_output("sb w_data", 32'(w_data), 32'(e.data));
                check_output("sb ack", 32'(ack), 32'(4'b0001 << e.id));
            end
        end
    endtask

    task automatic run(string tag, int n, logic [63:0] wp, logic [63:0] bp, logic [63:0] fp, int stall_gid);
        for (int c = 0; c < n; c++) begin
            full = fp[c];
            drive_inputs();
            @(negedge clk);
            check_output($sformatf("%s c%0d wr", tag, c), 32'(wr), 32'(wp[c]));
            check_output($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(bp[c]));
            if (!wp[c]) check_output($sformatf("%s c%0d ack", tag, c), 32'(ack), 32'd0);
            if (fp[c] && bp[c]) check_output($sformatf("%s c%0d stall gid", tag, c), 32'(grant_id), 32'(stall_gid));
            sample_writes();
            last_ack = ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (last_ack[i] && head[i] < tail[i]) head[i]++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        last_ack = '0;

        vecs[0]  = mk(4'b0001, 0, 32'h00000021, 0, 4'b0000, 0, 0, 8'h21);
        vecs[1]  = mk(4'b0001, 0, 32'h00000021, 1, 4'b0001, 1, 0, 8'h21);
        vecs[2]  = mk(4'b0001, 0, 32'h00000043, 1, 4'b0001, 1, 0, 8'h43);
        vecs[3]  = mk(4'b0000, 0, 32'h00000043, 0, 4'b0000, 1, 0, 8'h43);
        vecs[4]  = mk(4'b0000, 0, 32'h00000043, 0, 4'b0000, 0, 0, 8'h43);
        vecs[5]  = mk(4'b0011, 0, 32'h0000B1AA, 0, 4'b0000, 0, 0, 8'hAA);
        vecs[6]  = mk(4'b0011, 0, 32'h0000B1AA, 1, 4'b0010, 1, 1, 8'hB1);
        vecs[7]  = mk(4'b0001, 0, 32'h0000B1AA, 0, 4'b0000, 1, 1, 8'hB1);
        vecs[8]  = mk(4'b0001, 0, 32'h0000B1AA, 0, 4'b0000, 0, 1, 8'hB1);
        vecs[9]  = mk(4'b0001, 1, 32'h0000B1AA, 0, 4'b0000, 1, 0, 8'hAA);
        vecs[10] = mk(4'b0001, 0, 32'h0000B1AA, 1, 4'b0001, 1, 0, 8'hAA);
        vecs[11] = mk(4'b0000, 0, 32'h0000B1AA, 0, 4'b0000, 1, 0, 8'hAA);
        vecs[12] = mk(4'b0000, 0, 32'h0000B1AA, 0, 4'b0000, 0, 0, 8'hAA);
        vecs[13] = mk(4'b0100, 1, 32'h00C20000, 0, 4'b0000, 0, 0, 8'h00);
        vecs[14] = mk(4'b0100, 0, 32'h00C20000, 0, 4'b0000, 0, 0, 8'h00);
        vecs[15] = mk(4'b0100, 0, 32'h00C20000, 1, 4'b0100, 1, 2, 8'hC2);
        vecs[16] = mk(4'b0000, 0, 32'h00C20000, 0, 4'b0000, 1, 2, 8'hC2);
        vecs[17] = mk(4'b0000, 0, 32'h00C20000, 0, 4'b0000, 0, 2, 8'hC2);

        reset    = 1'b0;
        req      = 4'hF;
        req_data = 32'h44332211;
        full     = 1'b0;
        #2;
        check_output("reset wr", 32'(wr), 32'd0);
        check_output("reset ack", 32'(ack), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset grant_id", 32'(grant_id), 32'd0);
        check_output("reset w_data", 32'(w_data), 32'h11);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("held reset busy", 32'(busy), 32'd0);
        check_output("held reset wr", 32'(wr), 32'd0);
        req   = 4'h0;
        reset = 1'b1;

        $display("[TB] vector table");
        for (int v = 0; v < 18; v++) begin
            apply_stimulus(vecs[v]);
            @(negedge clk);
            check_output($sformatf("vec%0d wr", v), 32'(wr), 32'(vecs[v].exp_wr));
            check_output($sformatf("vec%0d ack", v), 32'(ack), 32'(vecs[v].exp_ack));
            check_output($sformatf("vec%0d busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            check_output($sformatf("vec%0d grant_id", v), 32'(grant_id), 32'(vecs[v].exp_gid));
            check_output($sformatf("vec%0d w_data", v), 32'(w_data), 32'(vecs[v].exp_wdata));
        end

        reset = 1'b0;
        #1;
        check_output("pulse reset grant_id", 32'(grant_id), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] all requesters, stall on requester 2");
        for (int k = 0; k < 4; k++) load(0, 8'h10, 1'b1);
        for (int k = 0; k < 4; k++) load(1, 8'h11, 1'b1);
        for (int k = 0; k < 4; k++) load(2, 8'h12, 1'b1);
        for (int k = 0; k < 4; k++) load(3, 8'h13, 1'b1);
        for (int k = 0; k < 4; k++) load(0, 8'h10, 1'b1);
        wr_pat   = bits(1, 4) | bits(6, 9) | bits(11, 12) | bits(16, 17) | bits(19, 22) | bits(24, 27);
        busy_pat = bits(1, 4) | bits(6, 9) | bits(11, 17) | bits(19, 22) | bits(24, 27);
        full_pat = bits(13, 15);
        run("all4", 30, wr_pat, busy_pat, full_pat, 2);

        $display("[TB] early release");
        load(1, 8'h51, 1'b1);
        load(1, 8'h52, 1'b1);
        load(2, 8'h61, 1'b1);
        load(2, 8'h62, 1'b1);
        load(2, 8'h63, 1'b1);
        run("early", 10, bits(1, 2) | bits(5, 7), bits(1, 3) | bits(5, 8), 64'd0, 0);

        $display("[TB] pointer wrap");
        load(3, 8'h71, 1'b1);
        run("own3", 4, bits(1, 1), bits(1, 2), 64'd0, 0);
        load(1, 8'h81, 1'b1);
        load(1, 8'h82, 1'b1);
        load(3, 8'h91, 1'b1);
        load(3, 8'h92, 1'b1);
        run("wrap", 9, bits(1, 2) | bits(5, 6), bits(1, 3) | bits(5, 7), 64'd0, 0);

        $display("[TB] reset mid-burst");
        load(3, 8'hA1, 1'b1);
        load(3, 8'hA2, 1'b1);
        load(3, 8'hA3, 1'b0);
        load(3, 8'hA4, 1'b0);
        run("burst3", 3, bits(1, 2), bits(1, 2), 64'd0, 0);
        drive_inputs();
        req_data[7:0] = 8'h5A;
        #1;
        check_output("pre-reset wr", 32'(wr), 32'd1);
        check_output("pre-reset grant_id", 32'(grant_id), 32'd3);
        reset = 1'b0;
        #1;
        check_output("mid reset wr", 32'(wr), 32'd0);
        check_output("mid reset ack", 32'(ack), 32'd0);
        check_output("mid reset busy", 32'(busy), 32'd0);
        check_output("mid reset grant_id", 32'(grant_id), 32'd0);
        check_output("mid reset w_data", 32'(w_data), 32'h5A);
        head[3] = tail[3];
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        check_output("in reset wr", 32'(wr), 32'd0);
        load(2, 8'hB1, 1'b1);
        drive_inputs();
        reset = 1'b1;
        #1;
        check_output("release cycle wr", 32'(wr), 32'd0);
        check_output("release cycle busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        run("after", 3, bits(0, 0), bits(0, 1), 64'd0, 0);

        check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
        check_output("fifo write count", 32'(written), 32'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
